// File: rtl/char_mem_writer.sv
// Write side of the 8-entry character memory: captures DATA on each KEYn press, normalises it, writes sequentially.
// Latency: press sampled at edge k -> CHECK at k+SYNC_STAGES -> MEM_WE high for the cycle after k+SYNC_STAGES+1.
// No backpressure: presses during CHECK/WRITE are dropped, presses in FULL_ST are ignored until CLEAR/RESET.
//
// Ports:
//   CLOCK, RESET (async, active high), KEYn (async, active-low button), DATA (ASCII from switches),
//   CLEAR (sync clear), MEM_ADDR/MEM_DATA/MEM_WE (memory write port), FULL, ERR (sticky bad code), COUNT.
module char_mem_writer #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              KEYn,
    input  logic [7:0]        DATA,
    input  logic              CLEAR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_DATA,
    output logic              MEM_WE,
    output logic              FULL,
    output logic              ERR,
    output logic [3:0]        COUNT
);

    // One extra bit so the pointer can sit at DEPTH after the last write instead of wrapping.
    localparam int WP_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, FULL_ST} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                r_sync_prev;
    logic                w_press;
    logic [7:0]          r_char;
    logic [7:0]          w_char_nxt;
    logic [7:0]          r_mem_data;
    logic [7:0]          w_mem_data_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [WP_W-1:0]     r_wptr;
    logic [WP_W-1:0]     w_wptr_nxt;
    logic [3:0]          r_count;
    logic [3:0]          w_count_nxt;
    logic [8:0]          w_norm;     // {valid, normalised code}

    // Returns {valid, code}; mixed-case mapping follows what a 7-segment digit can show.
    function automatic logic [8:0] norm_char(input logic [7:0] c);
        logic [8:0] r;
        r = 9'd0;
        case (c)
            8'd65,  8'd97:  r = {1'b1, 8'd65};
            8'd66,  8'd98:  r = {1'b1, 8'd98};
            8'd67,  8'd99:  r = {1'b1, 8'd67};
            8'd68,  8'd100: r = {1'b1, 8'd100};
            8'd69,  8'd101: r = {1'b1, 8'd69};
            8'd70,  8'd102: r = {1'b1, 8'd70};
            8'd71,  8'd103: r = {1'b1, 8'd103};
            8'd72,  8'd104: r = {1'b1, 8'd104};
            default:        r = 9'd0;
        endcase
        return r;
    endfunction

    // Synchroniser resets to "released" so reset release never looks like a press.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_sync      <= '1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], KEYn};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Falling edge of the synchronised key only: holding or releasing produces nothing.
    assign w_press = r_sync_prev & ~r_sync[SYNC_STAGES-1];
    assign w_norm  = norm_char(r_char);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_char     <= 8'd0;
            r_mem_data <= 8'd0;
            r_err      <= 1'b0;
            r_wptr     <= '0;
            r_count    <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_char     <= w_char_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_err      <= w_err_nxt;
            r_wptr     <= w_wptr_nxt;
            r_count    <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_char_nxt     = r_char;
        w_mem_data_nxt = r_mem_data;
        w_err_nxt      = r_err;
        w_wptr_nxt     = r_wptr;
        w_count_nxt    = r_count;

        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_char_nxt  = DATA;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (w_norm[8]) begin
                    w_mem_data_nxt = w_norm[7:0];
                    w_err_nxt      = 1'b0;
                    w_state_nxt    = WRITE;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WRITE: begin
                w_wptr_nxt  = r_wptr + WP_W'(1);
                w_count_nxt = r_count + 4'd1;
                w_state_nxt = (w_count_nxt == 4'(DEPTH)) ? FULL_ST : IDLE;
            end
            FULL_ST: begin
                w_state_nxt = FULL_ST;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Clear wins over any press or write in flight; MEM_DATA deliberately keeps its last value.
        if (CLEAR) begin
            w_state_nxt = IDLE;
            w_wptr_nxt  = '0;
            w_count_nxt = 4'd0;
            w_err_nxt   = 1'b0;
        end
    end

    assign MEM_ADDR = ADDR_W'(r_wptr);
    assign MEM_DATA = r_mem_data;
    // Gating with CLEAR aborts the write in the same cycle rather than just not counting it.
    assign MEM_WE   = (r_state == WRITE) && !CLEAR;
    assign FULL     = (r_count == 4'(DEPTH));
    assign ERR      = r_err;
    assign COUNT    = r_count;

endmodule

// File: tb/tb_char_mem_writer.sv
module tb_char_mem_writer;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       KEYn;
    logic [7:0] DATA;
    logic       CLEAR;
    logic [4:0] MEM_ADDR;
    logic [7:0] MEM_DATA;
    logic       MEM_WE;
    logic       FULL;
    logic       ERR;
    logic [3:0] COUNT;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];

    char_mem_writer #(.DEPTH(8), .ADDR_W(5), .SYNC_STAGES(2)) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .KEYn     (KEYn),
        .DATA     (DATA),
        .CLEAR    (CLEAR),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DATA (MEM_DATA),
        .MEM_WE   (MEM_WE),
        .FULL     (FULL),
        .ERR      (ERR),
        .COUNT    (COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    // Monitor: every write seen on the port must match the oldest expected write.
    always @(negedge CLOCK) begin
        if (!RESET && MEM_WE) begin
            wr_t e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", MEM_ADDR, MEM_DATA);
            end else begin
                e = exp_q.pop_front();
                if (MEM_ADDR !== e.addr || MEM_DATA !== e.data) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             MEM_ADDR, MEM_DATA, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic expect_wr(input int addr, input int data);
        wr_t e;
        e.addr = 5'(addr);
        e.data = 8'(data);
        exp_q.push_back(e);
    endtask

    // Press for 'hold' sampled edges, then allow the write to complete.
    task automatic press(input int d, input int hold = 1);
        DATA = 8'(d);
        KEYn = 1'b0;
        tick(hold);
        KEYn = 1'b1;
        tick(8);
    endtask

    task automatic do_clear();
        CLEAR = 1'b1;
        tick(1);
        CLEAR = 1'b0;
        tick(1);
    endtask

    int raw_d  [8] = '{65, 97, 98, 66, 67, 99, 100, 68};
    int norm_d [8] = '{65, 65, 98, 98, 67, 67, 100, 100};

    initial begin
        int seen;
        RESET = 1'b1;
        KEYn  = 1'b1;
        DATA  = 8'd0;
        CLEAR = 1'b0;
        tick(3);
        check("rst_we",    MEM_WE,   0);
        check("rst_count", COUNT,    0);
        check("rst_full",  FULL,     0);
        check("rst_err",   ERR,      0);
        check("rst_addr",  MEM_ADDR, 0);
        check("rst_data",  MEM_DATA, 0);
        RESET = 1'b0;
        tick(3);
        check("post_rst_no_press_count", COUNT, 0);

        // 1) single press with exact latency
        expect_wr(0, 65);
        DATA = 8'd65;
        KEYn = 1'b0;            // sampled at edge k
        tick(3);                // now just after edge k+2: CHECK
        check("lat_we_in_check", MEM_WE, 0);
        tick(1);                // just after edge k+3: WRITE
        check("lat_we_in_write", MEM_WE, 1);
        tick(1);
        check("lat_we_one_cycle", MEM_WE, 0);
        KEYn = 1'b1;
        tick(6);
        check("t1_count", COUNT, 1);

        // 2) lower/upper-case normalisation
        do_clear();
        expect_wr(0, 65);  press(97);
        expect_wr(1, 98);  press(66);
        expect_wr(2, 103); press(71);
        check("t2_err",   ERR,   0);
        check("t2_count", COUNT, 3);

        // 3) unsupported code sets ERR, next valid one clears it
        press(90);
        check("t3_err_set",   ERR,   1);
        check("t3_count_same", COUNT, 3);
        expect_wr(3, 67); press(99);
        check("t3_err_clr", ERR,   0);
        check("t3_count",   COUNT, 4);

        // 4) fill to DEPTH, extra presses ignored, then clear
        do_clear();
        for (int i = 0; i < 8; i++) begin
            expect_wr(i, norm_d[i]);
            press(raw_d[i]);
        end
        check("t4_full",  FULL,  1);
        check("t4_count", COUNT, 8);
        press(69);
        press(90);
        check("t4_full_hold",  COUNT, 8);
        check("t4_err_unchg",  ERR,   0);
        do_clear();
        check("t4_clr_count", COUNT, 0);
        check("t4_clr_full",  FULL,  0);
        expect_wr(0, 69); press(101);
        check("t4_after_clr", COUNT, 1);

        // 5) long hold gives one write; a sub-cycle glitch is never sampled
        do_clear();
        expect_wr(0, 70); press(102, 50);
        check("t5_hold_count", COUNT, 1);
        DATA = 8'd65;
        @(posedge CLOCK); #1;
        KEYn = 1'b0; #3; KEYn = 1'b1;
        tick(8);
        check("t5_glitch_count", COUNT, 1);
        // second press lands in the WRITE cycle of the first and is dropped
        expect_wr(1, 104);
        DATA = 8'd72;
        KEYn = 1'b0; tick(1);
        KEYn = 1'b1; tick(1);
        KEYn = 1'b0; tick(1);
        KEYn = 1'b1; tick(10);
        check("t5_drop_count", COUNT, 2);
        check("t5_drop_addr",  MEM_ADDR, 2);

        // 6) reset during WRITE kills MEM_WE immediately
        DATA = 8'd104;
        KEYn = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            tick(1);
            if (MEM_WE) seen = 1;
        end
        check("t6_reached_write", seen, 1);
        RESET = 1'b1;
        #1;
        check("t6_we_async", MEM_WE, 0);
        check("t6_count",    COUNT,  0);
        KEYn = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick(3);
        // CLEAR coincident with the press window: no write
        DATA  = 8'd65;
        CLEAR = 1'b1;
        KEYn  = 1'b0; tick(1);
        KEYn  = 1'b1; tick(4);
        CLEAR = 1'b0;
        tick(6);
        check("t6_clr_press_count", COUNT, 0);
        expect_wr(0, 65); press(65);
        check("t6_final_count", COUNT, 1);

        tick(3);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound in case the stimulus stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
